// File: rtl/morse_pkg.sv
// Shared constants, payload types and FSM encoding for the Morse letter transmitter.
// Optional feature: define MORSE_WORD_GAP_EN to append a 7-unit word gap before done.
package morse_pkg;

    localparam int unsigned CODE_W  = 6;
    localparam int unsigned UNITS_W = 3;

    // Letter codes as produced by the letter entry buffer
    localparam logic [CODE_W-1:0] LTR_EMPTY = 6'd0;
    localparam logic [CODE_W-1:0] LTR_A = 6'd1,  LTR_B = 6'd2,  LTR_C = 6'd3,  LTR_D = 6'd4;
    localparam logic [CODE_W-1:0] LTR_E = 6'd5,  LTR_F = 6'd6,  LTR_G = 6'd7,  LTR_H = 6'd8;
    localparam logic [CODE_W-1:0] LTR_I = 6'd9,  LTR_J = 6'd10, LTR_K = 6'd11, LTR_L = 6'd12;
    localparam logic [CODE_W-1:0] LTR_M = 6'd13, LTR_N = 6'd14, LTR_O = 6'd15, LTR_P = 6'd16;
    localparam logic [CODE_W-1:0] LTR_Q = 6'd17, LTR_R = 6'd18, LTR_S = 6'd19, LTR_T = 6'd20;
    localparam logic [CODE_W-1:0] LTR_U = 6'd21, LTR_V = 6'd22, LTR_W = 6'd23, LTR_X = 6'd24;
    localparam logic [CODE_W-1:0] LTR_Y = 6'd25, LTR_Z = 6'd26;

    // Element and gap lengths in Morse time units
    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned SYM_GAP    = 1;
    localparam int unsigned LTR_GAP    = 3;
    localparam int unsigned WORD_GAP   = 7;

    // One letter: symbol count and left-aligned pattern (bit 3 sent first, 1 = dash)
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [3:0] pat;
    } morse_sym_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MARK  = 3'd2,
        ST_SPACE = 3'd3,
        ST_LGAP  = 3'd4,
`ifdef MORSE_WORD_GAP_EN
        ST_WGAP  = 3'd5,
`endif
        ST_DONE  = 3'd6
    } state_t;

    function automatic logic letter_valid(input logic [CODE_W-1:0] code);
        return (code >= LTR_A) && (code <= LTR_Z);
    endfunction

    function automatic logic [UNITS_W-1:0] mark_units(input logic dash);
        return dash ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
    endfunction

endpackage

// File: rtl/letter_morse_tx_if.sv
// Control/display bus between the word controller and the Morse transmitter.
interface letter_morse_tx_if;
    import morse_pkg::*;

    logic              start;
    logic [CODE_W-1:0] letter1;
    logic [CODE_W-1:0] letter2;
    logic [CODE_W-1:0] letter3;
    logic              tx;
    logic              busy;
    logic              done;
    logic [1:0]        letter_idx;

    modport master (
        output start, letter1, letter2, letter3,
        input  tx, busy, done, letter_idx
    );

    modport slave (
        input  start, letter1, letter2, letter3,
        output tx, busy, done, letter_idx
    );

endinterface

// File: rtl/morse_rom.sv
// Combinational letter code -> Morse pattern lookup; codes outside A..Z report valid=0.
module morse_rom
    import morse_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output morse_sym_t        sym_c
);

    function automatic morse_sym_t mk(input logic [2:0] len, input logic [3:0] pat);
        return '{valid: 1'b1, len: len, pat: pat};
    endfunction

    // Pattern table, symbols left-aligned
    always_comb begin
        sym_c = '0;
        case (code)
            LTR_A: sym_c = mk(3'd2, 4'b0100);
            LTR_B: sym_c = mk(3'd4, 4'b1000);
            LTR_C: sym_c = mk(3'd4, 4'b1010);
            LTR_D: sym_c = mk(3'd3, 4'b1000);
            LTR_E: sym_c = mk(3'd1, 4'b0000);
            LTR_F: sym_c = mk(3'd4, 4'b0010);
            LTR_G: sym_c = mk(3'd3, 4'b1100);
            LTR_H: sym_c = mk(3'd4, 4'b0000);
            LTR_I: sym_c = mk(3'd2, 4'b0000);
            LTR_J: sym_c = mk(3'd4, 4'b0111);
            LTR_K: sym_c = mk(3'd3, 4'b1010);
            LTR_L: sym_c = mk(3'd4, 4'b0100);
            LTR_M: sym_c = mk(3'd2, 4'b1100);
            LTR_N: sym_c = mk(3'd2, 4'b1000);
            LTR_O: sym_c = mk(3'd3, 4'b1110);
            LTR_P: sym_c = mk(3'd4, 4'b0110);
            LTR_Q: sym_c = mk(3'd4, 4'b1101);
            LTR_R: sym_c = mk(3'd3, 4'b0100);
            LTR_S: sym_c = mk(3'd3, 4'b0000);
            LTR_T: sym_c = mk(3'd1, 4'b1000);
            LTR_U: sym_c = mk(3'd3, 4'b0010);
            LTR_V: sym_c = mk(3'd4, 4'b0001);
            LTR_W: sym_c = mk(3'd3, 4'b0110);
            LTR_X: sym_c = mk(3'd4, 4'b1001);
            LTR_Y: sym_c = mk(3'd4, 4'b1011);
            LTR_Z: sym_c = mk(3'd4, 4'b1100);
            default: sym_c = '0;
        endcase
    end

endmodule

// File: rtl/letter_morse_tx.sv
// Keys out a snapshotted 3-letter word as Morse code on tx.
// Optional feature: MORSE_WORD_GAP_EN adds a 7-unit silent word gap before done.
// All bus outputs are registered images of the FSM state of the previous cycle.
module letter_morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 6_000_000
) (
    input  logic               clk,
    input  logic               rst,
    letter_morse_tx_if.slave   bus
);

    localparam int unsigned CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    state_t                        state_q, state_d;
    logic [2:0][CODE_W-1:0]        letters_q, letters_d;
    logic [2:0]                    mask_q, mask_d;
    logic [1:0]                    ptr_q, ptr_d;
    logic [3:0]                    pat_q, pat_d;
    logic [2:0]                    sym_left_q, sym_left_d;
    logic [UNITS_W-1:0]            units_rem_q, units_rem_d;
    logic [CNT_W-1:0]              unit_cnt_q, unit_cnt_d;
    logic                          tx_q, tx_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [1:0]                    idx_q, idx_d;

    logic [CODE_W-1:0]             cur_code_c;
    morse_sym_t                    cur_sym_c;
    logic                          timed_c;
    logic                          unit_tick_c;
    logic                          phase_end_c;
    logic                          later_valid_c;

    // Pattern lookup for the slot under the pointer; slot 3 means "past the end"
    assign cur_code_c = (ptr_q == 2'd3) ? LTR_EMPTY : letters_q[ptr_q];

    morse_rom u_rom (
        .code  (cur_code_c),
        .sym_c (cur_sym_c)
    );

    // Unit timing and lookahead for a valid letter after the current slot
    always_comb begin
        timed_c = 1'b0;
        case (state_q)
            ST_MARK, ST_SPACE, ST_LGAP: timed_c = 1'b1;
`ifdef MORSE_WORD_GAP_EN
            ST_WGAP:                    timed_c = 1'b1;
`endif
            default:                    timed_c = 1'b0;
        endcase
        unit_tick_c   = (unit_cnt_q == CNT_W'(UNIT_CYCLES - 1));
        phase_end_c   = timed_c && unit_tick_c && (units_rem_q == UNITS_W'(1));
        later_valid_c = 1'b0;
        case (ptr_q)
            2'd0:    later_valid_c = mask_q[1] | mask_q[2];
            2'd1:    later_valid_c = mask_q[2];
            default: later_valid_c = 1'b0;
        endcase
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d     = state_q;
        letters_d   = letters_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        pat_d       = pat_q;
        sym_left_d  = sym_left_q;
        units_rem_d = units_rem_q;
        unit_cnt_d  = '0;
        if (timed_c) begin
            unit_cnt_d = unit_tick_c ? '0 : unit_cnt_q + CNT_W'(1);
            if (unit_tick_c && !phase_end_c) begin
                units_rem_d = units_rem_q - UNITS_W'(1);
            end
        end
        tx_d   = (state_q == ST_MARK);
        busy_d = (state_q != ST_IDLE);
        done_d = (state_q == ST_DONE);
        idx_d  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) ? 2'd0 :
                 ((ptr_q == 2'd3) ? 2'd2 : ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    letters_d = {bus.letter3, bus.letter2, bus.letter1};
                    mask_d    = {letter_valid(bus.letter3), letter_valid(bus.letter2),
                                 letter_valid(bus.letter1)};
                    ptr_d     = 2'd0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ptr_q == 2'd3) begin
`ifdef MORSE_WORD_GAP_EN
                    state_d     = ST_WGAP;
                    units_rem_d = UNITS_W'(WORD_GAP);
`else
                    state_d     = ST_DONE;
`endif
                end else if (cur_sym_c.valid) begin
                    pat_d       = cur_sym_c.pat;
                    sym_left_d  = cur_sym_c.len;
                    units_rem_d = mark_units(cur_sym_c.pat[3]);
                    state_d     = ST_MARK;
                end else begin
                    ptr_d = ptr_q + 2'd1;
                end
            end
            ST_MARK: begin
                if (phase_end_c) begin
                    if (sym_left_q > 3'd1) begin
                        pat_d       = {pat_q[2:0], 1'b0};
                        sym_left_d  = sym_left_q - 3'd1;
                        units_rem_d = UNITS_W'(SYM_GAP);
                        state_d     = ST_SPACE;
                    end else if (later_valid_c) begin
                        units_rem_d = UNITS_W'(LTR_GAP);
                        state_d     = ST_LGAP;
                    end else begin
`ifdef MORSE_WORD_GAP_EN
                        state_d     = ST_WGAP;
                        units_rem_d = UNITS_W'(WORD_GAP);
`else
                        state_d     = ST_DONE;
`endif
                    end
                end
            end
            ST_SPACE: begin
                if (phase_end_c) begin
                    units_rem_d = mark_units(pat_q[3]);
                    state_d     = ST_MARK;
                end
            end
            ST_LGAP: begin
                if (phase_end_c) begin
                    ptr_d   = ptr_q + 2'd1;
                    state_d = ST_LOAD;
                end
            end
`ifdef MORSE_WORD_GAP_EN
            ST_WGAP: begin
                if (phase_end_c) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            letters_q   <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            pat_q       <= '0;
            sym_left_q  <= '0;
            units_rem_q <= '0;
            unit_cnt_q  <= '0;
            tx_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            letters_q   <= letters_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            pat_q       <= pat_d;
            sym_left_q  <= sym_left_d;
            units_rem_q <= units_rem_d;
            unit_cnt_q  <= unit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.letter_idx = idx_q;

endmodule

// File: tb/tb_letter_morse_tx.sv
// Self-checking bench for letter_morse_tx: directed words plus random words,
// compared cycle by cycle against a timeline built from Morse timing rules.
module tb_letter_morse_tx;
    import morse_pkg::*;

    localparam int unsigned U = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    letter_morse_tx_if bus ();

    letter_morse_tx #(.UNIT_CYCLES(U)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } obs_t;

    obs_t exp_q[$];

    string morse_tab [27] = '{"",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--.."};

    function automatic bit is_letter(input logic [5:0] c);
        return (int'(c) >= 1) && (int'(c) <= 26);
    endfunction

    function automatic void push(input logic tx, input int idx, input int n);
        obs_t o;
        o.tx   = tx;
        o.busy = 1'b1;
        o.done = 1'b0;
        o.idx  = 2'(idx);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    // Expected output per cycle, starting the cycle after the start edge
    function automatic void build(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        logic [5:0] codes [3];
        bit    finished;
        bit    later;
        int    last_idx;
        int    s;
        string m;
        obs_t  o;
        codes[0] = a; codes[1] = b; codes[2] = c;
        exp_q.delete();
        finished = 1'b0;
        last_idx = 0;
        for (s = 0; s < 3 && !finished; s++) begin
            push(1'b0, s, 1);
            if (is_letter(codes[s])) begin
                m = morse_tab[int'(codes[s])];
                for (int i = 0; i < m.len(); i++) begin
                    push(1'b1, s, (m[i] == "-") ? 3 * U : U);
                    if (i < m.len() - 1) push(1'b0, s, U);
                end
                later = 1'b0;
                for (int j = s + 1; j < 3; j++) if (is_letter(codes[j])) later = 1'b1;
                if (later) begin
                    push(1'b0, s, 3 * U);
                end else begin
                    finished = 1'b1;
                    last_idx = s;
                end
            end
        end
        if (!finished) begin
            push(1'b0, 2, 1);
            last_idx = 2;
        end
`ifdef MORSE_WORD_GAP_EN
        push(1'b0, last_idx, 7 * U);
`endif
        o = '{tx: 1'b0, busy: 1'b1, done: 1'b1, idx: 2'd0};
        exp_q.push_back(o);
        o = '0;
        exp_q.push_back(o);
    endfunction

    task automatic check(input string tag, input int k, input obs_t want);
        obs_t got;
        got = '{tx: bus.tx, busy: bus.busy, done: bus.done, idx: bus.letter_idx};
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed tx=%b busy=%b done=%b idx=%0d, expected tx=%b busy=%b done=%b idx=%0d",
                   tag, k, got.tx, got.busy, got.done, got.idx,
                   want.tx, want.busy, want.done, want.idx);
        end
    endtask

    function automatic logic [5:0] rand_code();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 6'd0;
        if (r == 2) return 6'($urandom_range(27, 63));
        return 6'($urandom_range(1, 26));
    endfunction

    task automatic run_word(input string tag, input logic [5:0] a, input logic [5:0] b,
                            input logic [5:0] c, input bit hold, input bit scramble);
        build(a, b, c);
        @(negedge clk);
        bus.letter1 = a;
        bus.letter2 = b;
        bus.letter3 = c;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk);
            #1;
            check(tag, k, exp_q[k]);
            if (scramble && k == 2) begin
                bus.letter1 = rand_code();
                bus.letter2 = rand_code();
                bus.letter3 = rand_code();
            end
            if (hold && exp_q[k].done) bus.start = 1'b0;
        end
    endtask

    initial begin
        obs_t zero;
        obs_t mark_busy;
        zero      = '0;
        mark_busy = '{tx: 1'b1, busy: 1'b1, done: 1'b0, idx: 2'd0};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.letter1 = '0;
        bus.letter2 = '0;
        bus.letter3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, zero);
        @(negedge clk);
        rst = 1'b0;

        run_word("M",     6'd13, 6'd0,  6'd0,  1'b0, 1'b0);
        run_word("MS",    6'd13, 6'd19, 6'd0,  1'b0, 1'b0);
        run_word("empty", 6'd0,  6'd0,  6'd0,  1'b0, 1'b0);
        run_word("S_M",   6'd19, 6'd0,  6'd13, 1'b0, 1'b0);
        run_word("inv_E", 6'd40, 6'd5,  6'd63, 1'b0, 1'b0);
        run_word("__T",   6'd0,  6'd0,  6'd20, 1'b0, 1'b0);
        run_word("ZQY",   6'd26, 6'd17, 6'd25, 1'b0, 1'b0);

        // Reset in the middle of the first dash of M
        @(negedge clk);
        bus.letter1 = 6'd13;
        bus.letter2 = 6'd0;
        bus.letter3 = 6'd0;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_dash", 0, mark_busy);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst", 0, zero);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", k, zero);
        end
        run_word("restart_M", 6'd13, 6'd0, 6'd0, 1'b0, 1'b0);

        // Start held high and inputs scrambled mid-word
        run_word("hold_scr", 6'd1, 6'd2, 6'd3, 1'b1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            run_word($sformatf("rnd%0d", n), rand_code(), rand_code(), rand_code(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
